// File: rtl/queue_calc_sequencer_if.sv
// Token, queue-command, ALU and result signals of the calculator sequencer.
// The sequencer connects through the slave modport; its environment uses master.
interface queue_calc_sequencer_if;
    logic        tok_valid;
    logic        tok_ready;
    logic [1:0]  tok_kind;
    logic [7:0]  tok_data;
    logic [15:0] q_top;
    logic        q_en;
    logic [1:0]  q_opcode;
    logic [7:0]  q_back;
    logic        alu_start;
    logic [1:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_done;
    logic [7:0]  alu_result;
    logic        res_valid;
    logic [7:0]  res_data;
    logic        res_ready;
    logic        err;
    logic [1:0]  err_code;
    logic        err_clr;
    logic [2:0]  count;

    modport master (
        output tok_valid, tok_kind, tok_data, q_top, alu_done, alu_result, res_ready, err_clr,
        input  tok_ready, q_en, q_opcode, q_back, alu_start, alu_op, alu_a, alu_b,
               res_valid, res_data, err, err_code, count
    );

    modport slave (
        input  tok_valid, tok_kind, tok_data, q_top, alu_done, alu_result, res_ready, err_clr,
        output tok_ready, q_en, q_opcode, q_back, alu_start, alu_op, alu_a, alu_b,
               res_valid, res_data, err, err_code, count
    );
endinterface

// File: rtl/queue_calc_sequencer.sv
// RPN token sequencer driving the byte calculator queue and shared ALU.
// Optional ALU watchdog: define QSEQ_ALU_TIMEOUT_EN.
module queue_calc_sequencer #(
    parameter int DEPTH          = 5,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    queue_calc_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_PUSH, S_ALU_REQ, S_ALU_WAIT, S_WRITEBACK, S_RESULT, S_ERROR, S_FLUSH
    } state_t;

    localparam logic [1:0] K_OPERAND    = 2'b00;
    localparam logic [1:0] K_OPERATOR   = 2'b01;
    localparam logic [1:0] OP_PUSH      = 2'b00;
    localparam logic [1:0] OP_POP_PAIR  = 2'b10;
    localparam logic [1:0] OP_POP_FRONT = 2'b11;
    localparam logic [1:0] E_OVERFLOW   = 2'b01;
    localparam logic [1:0] E_UNDERFLOW  = 2'b10;
    localparam logic [1:0] E_BAD_END    = 2'b11;
    localparam logic [2:0] DEPTH_C      = 3'(DEPTH);

    if (DEPTH < 2 || DEPTH > 7 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
        $error("queue_calc_sequencer: DEPTH must be 2..7 and TIMEOUT_CYCLES 1..255");
    end

    state_t     state;
    logic [2:0] count_r;
    logic       tok_ready_r;
    logic       q_en_r;
    logic [1:0] q_opcode_r;
    logic [7:0] q_back_r;
    logic       alu_start_r;
    logic [1:0] alu_op_r;
    logic [7:0] alu_a_r;
    logic [7:0] alu_b_r;
    logic       res_valid_r;
    logic [7:0] res_data_r;
    logic       err_r;
    logic [1:0] err_code_r;

`ifdef QSEQ_ALU_TIMEOUT_EN
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wdog;
`endif

    // Occupancy saturates at both ends so the mirror can never wrap.
    function automatic logic [2:0] cnt_inc(input logic [2:0] c);
        return (c >= DEPTH_C) ? DEPTH_C : c + 3'd1;
    endfunction

    function automatic logic [2:0] cnt_dec(input logic [2:0] c);
        return (c == 3'd0) ? 3'd0 : c - 3'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            count_r     <= 3'd0;
            tok_ready_r <= 1'b1;
            q_en_r      <= 1'b0;
            q_opcode_r  <= 2'b00;
            q_back_r    <= 8'h00;
            alu_start_r <= 1'b0;
            alu_op_r    <= 2'b00;
            alu_a_r     <= 8'h00;
            alu_b_r     <= 8'h00;
            res_valid_r <= 1'b0;
            res_data_r  <= 8'h00;
            err_r       <= 1'b0;
            err_code_r  <= 2'b00;
`ifdef QSEQ_ALU_TIMEOUT_EN
            wdog        <= 8'h00;
`endif
        end else begin
            q_en_r      <= 1'b0;
            alu_start_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.tok_valid) begin
                        tok_ready_r <= 1'b0;
                        case (bus.tok_kind)
                            K_OPERAND: begin
                                if (count_r < DEPTH_C) begin
                                    state      <= S_PUSH;
                                    q_en_r     <= 1'b1;
                                    q_opcode_r <= OP_PUSH;
                                    q_back_r   <= bus.tok_data;
                                end else begin
                                    state      <= S_ERROR;
                                    err_r      <= 1'b1;
                                    err_code_r <= E_OVERFLOW;
                                end
                            end
                            K_OPERATOR: begin
                                if (count_r >= 3'd2) begin
                                    state       <= S_ALU_REQ;
                                    alu_start_r <= 1'b1;
                                    alu_op_r    <= bus.tok_data[1:0];
                                    alu_a_r     <= bus.q_top[15:8];
                                    alu_b_r     <= bus.q_top[7:0];
`ifdef QSEQ_ALU_TIMEOUT_EN
                                    wdog        <= 8'h00;
`endif
                                end else begin
                                    state      <= S_ERROR;
                                    err_r      <= 1'b1;
                                    err_code_r <= E_UNDERFLOW;
                                end
                            end
                            default: begin
                                // Reserved kind behaves as an end token.
                                if (count_r == 3'd1) begin
                                    state       <= S_RESULT;
                                    res_valid_r <= 1'b1;
                                    res_data_r  <= bus.q_top[15:8];
                                end else begin
                                    state      <= S_ERROR;
                                    err_r      <= 1'b1;
                                    err_code_r <= E_BAD_END;
                                end
                            end
                        endcase
                    end
                end
                S_PUSH: begin
                    count_r     <= cnt_inc(count_r);
                    state       <= S_IDLE;
                    tok_ready_r <= 1'b1;
                end
                S_ALU_REQ: begin
                    // A done pulse coincident with the launch is deliberately not looked at.
                    state <= S_ALU_WAIT;
                end
                S_ALU_WAIT: begin
                    if (bus.alu_done) begin
                        state      <= S_WRITEBACK;
                        q_en_r     <= 1'b1;
                        q_opcode_r <= OP_POP_PAIR;
                        q_back_r   <= bus.alu_result;
                    end
`ifdef QSEQ_ALU_TIMEOUT_EN
                    else if (wdog == WDOG_LAST) begin
                        state      <= S_ERROR;
                        err_r      <= 1'b1;
                        err_code_r <= E_BAD_END;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
`endif
                end
                S_WRITEBACK: begin
                    count_r     <= cnt_dec(count_r);
                    state       <= S_IDLE;
                    tok_ready_r <= 1'b1;
                end
                S_RESULT: begin
                    if (bus.res_ready) begin
                        res_valid_r <= 1'b0;
                        res_data_r  <= 8'h00;
                        q_en_r      <= 1'b1;
                        q_opcode_r  <= OP_POP_FRONT;
                        count_r     <= 3'd0;
                        state       <= S_IDLE;
                        tok_ready_r <= 1'b1;
                    end
                end
                S_ERROR: begin
                    if (bus.err_clr) begin
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    // Drain one entry per cycle; the error clears only once empty.
                    if (count_r != 3'd0) begin
                        q_en_r     <= 1'b1;
                        q_opcode_r <= OP_POP_FRONT;
                        count_r    <= cnt_dec(count_r);
                    end else begin
                        err_r       <= 1'b0;
                        err_code_r  <= 2'b00;
                        state       <= S_IDLE;
                        tok_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    tok_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.tok_ready = tok_ready_r;
    assign bus.q_en      = q_en_r;
    assign bus.q_opcode  = q_opcode_r;
    assign bus.q_back    = q_back_r;
    assign bus.alu_start = alu_start_r;
    assign bus.alu_op    = alu_op_r;
    assign bus.alu_a     = alu_a_r;
    assign bus.alu_b     = alu_b_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res_data  = res_data_r;
    assign bus.err       = err_r;
    assign bus.err_code  = err_code_r;
    assign bus.count     = count_r;
endmodule

// File: tb/tb_queue_calc_sequencer.sv
// Bench for queue_calc_sequencer: queue/ALU environment models, directed table, RPN reference model.
module tb_queue_calc_sequencer;
    localparam int DEPTH  = 5;
    localparam int TO     = 8;
    localparam int BUDGET = 50;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    queue_calc_sequencer_if bus();
    queue_calc_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    logic [7:0]  envq[$];
    logic [9:0]  obs_q[$];
    logic [17:0] obs_alu[$];
    logic [7:0]  mq[$];
    bit          alu_mute = 1'b0;
    int          late_req = 0;

    typedef struct {
        logic [1:0]  kind;
        logic [7:0]  data;
        int          hold;
        int          ncmd;
        logic [9:0]  cmd;
        bit          chk_back;
        int          nalu;
        logic [17:0] alu;
        bit          rseen;
        logic [7:0]  rdata;
        bit          err;
        logic [1:0]  code;
        int          flush;
        logic [2:0]  cnt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] alu_fn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    // External queue: commands seen during a cycle take effect at the following edge.
    initial begin
        logic       en_s, rst_s;
        logic [1:0] op_s;
        logic [7:0] bk_s;
        bus.q_top = 16'h0000;
        forever begin
            @(negedge clk);
            en_s = bus.q_en; op_s = bus.q_opcode; bk_s = bus.q_back; rst_s = rst;
            if (en_s) obs_q.push_back({op_s, bk_s});
            @(posedge clk);
            #1;
            if (!rst_s) envq.delete();
            else if (en_s) begin
                case (op_s)
                    2'b00: envq.push_back(bk_s);
                    2'b01: begin if (envq.size() > 0) void'(envq.pop_front()); envq.push_back(bk_s); end
                    2'b10: begin
                        if (envq.size() > 0) void'(envq.pop_front());
                        if (envq.size() > 0) void'(envq.pop_front());
                        envq.push_back(bk_s);
                    end
                    default: if (envq.size() > 0) void'(envq.pop_front());
                endcase
            end
            bus.q_top = {(envq.size() > 0) ? envq[0] : 8'h00, (envq.size() > 1) ? envq[1] : 8'h00};
        end
    end

    // ALU: a bogus done pulse in the launch cycle, then the real result after 1..4 cycles.
    initial begin
        int late_seen;
        int lat;
        logic [7:0] a, b;
        logic [1:0] op;
        late_seen = 0;
        bus.alu_done = 1'b0; bus.alu_result = 8'h00;
        forever begin
            @(negedge clk);
            if (late_req != late_seen) begin
                late_seen = late_req;
                tick(); bus.alu_done = 1'b1; bus.alu_result = 8'h55;
                tick(); bus.alu_done = 1'b0;
            end else if (bus.alu_start && !alu_mute) begin
                a = bus.alu_a; b = bus.alu_b; op = bus.alu_op;
                obs_alu.push_back({op, a, b});
                lat = $urandom_range(1, 4);
                bus.alu_done = 1'b1; bus.alu_result = ~alu_fn(op, a, b);
                tick(); bus.alu_done = 1'b0;
                repeat (lat - 1) tick();
                bus.alu_done = 1'b1; bus.alu_result = alu_fn(op, a, b);
                tick(); bus.alu_done = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic send(input logic [1:0] kind, input logic [7:0] data);
        int n = 0;
        while (!bus.tok_ready && n < BUDGET) begin tick(); n++; end
        chk("tok_ready_wait", bus.tok_ready, 1);
        bus.tok_valid = 1'b1; bus.tok_kind = kind; bus.tok_data = data;
        tick();
        bus.tok_valid = 1'b0;
    endtask

    task automatic run_token(input logic [1:0] kind, input logic [7:0] data, input int hold,
                             output int ncmd, output logic [9:0] cmd0, output int nalu,
                             output logic [17:0] alu0, output bit rseen, output logic [7:0] rdata);
        int qb = obs_q.size();
        int ab = obs_alu.size();
        int n = 0;
        rseen = 1'b0; rdata = 8'h00;
        send(kind, data);
        while (!bus.tok_ready && !bus.err && !bus.res_valid && n < BUDGET) begin tick(); n++; end
        if (bus.res_valid) begin
            rseen = 1'b1; rdata = bus.res_data;
            for (int i = 0; i < hold; i++) begin
                tick();
                chk("res_hold_valid", bus.res_valid, 1);
                chk("res_hold_data", bus.res_data, rdata);
            end
            bus.res_ready = 1'b1;
            tick();
            bus.res_ready = 1'b0;
            n = 0;
            while (!bus.tok_ready && n < BUDGET) begin tick(); n++; end
        end
        chk("settle", bus.tok_ready | bus.err, 1);
        tick();
        ncmd = obs_q.size() - qb;
        cmd0 = (ncmd > 0) ? obs_q[qb] : 10'h000;
        nalu = obs_alu.size() - ab;
        alu0 = (nalu > 0) ? obs_alu[ab] : 18'h0;
    endtask

    task automatic clear_err(output int nflush, output bit all_pop);
        int qb = obs_q.size();
        int n = 0;
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        while (!bus.tok_ready && n < BUDGET) begin tick(); n++; end
        tick();
        nflush = obs_q.size() - qb;
        all_pop = 1'b1;
        for (int i = qb; i < obs_q.size(); i++) if (obs_q[i][9:8] != 2'b11) all_pop = 1'b0;
        chk("clr_err", bus.err, 0);
        chk("clr_code", bus.err_code, 0);
        chk("clr_count", bus.count, 0);
        chk("clr_tok_ready", bus.tok_ready, 1);
    endtask

    // Reference: queue-level RPN evaluation of one token.
    task automatic model_step(input logic [1:0] kind, input logic [7:0] data, input int hold);
        int ncmd, nalu, nf;
        logic [9:0] cmd0;
        logic [17:0] alu0;
        bit rseen, ap, eerr;
        logic [7:0] rdata, a, b, r;
        logic [1:0] ecode;
        eerr = 1'b0; ecode = 2'b00;
        run_token(kind, data, hold, ncmd, cmd0, nalu, alu0, rseen, rdata);
        if (kind == 2'b00) begin
            if (mq.size() < DEPTH) begin
                chk("m_push_n", ncmd, 1);
                chk("m_push_cmd", cmd0, {2'b00, data});
                mq.push_back(data);
            end else begin eerr = 1'b1; ecode = 2'b01; end
        end else if (kind == 2'b01) begin
            if (mq.size() >= 2) begin
                a = mq[0]; b = mq[1]; r = alu_fn(data[1:0], a, b);
                chk("m_alu_n", nalu, 1);
                chk("m_alu_args", alu0, {data[1:0], a, b});
                chk("m_wb_n", ncmd, 1);
                chk("m_wb_cmd", cmd0, {2'b10, r});
                void'(mq.pop_front()); void'(mq.pop_front()); mq.push_back(r);
            end else begin eerr = 1'b1; ecode = 2'b10; chk("m_no_alu", nalu, 0); end
        end else begin
            if (mq.size() == 1) begin
                chk("m_res_seen", rseen, 1);
                chk("m_res_data", rdata, mq[0]);
                chk("m_res_pop_n", ncmd, 1);
                chk("m_res_pop_op", cmd0[9:8], 2'b11);
                mq.delete();
            end else begin eerr = 1'b1; ecode = 2'b11; end
        end
        if (eerr) begin
            chk("m_err", bus.err, 1);
            chk("m_err_code", bus.err_code, ecode);
            chk("m_err_no_q", ncmd, 0);
            clear_err(nf, ap);
            chk("m_flush_n", nf, mq.size());
            chk("m_flush_op", ap, 1);
            mq.delete();
        end
        chk("m_count", bus.count, mq.size());
        chk("m_err_idle", bus.err, 0);
    endtask

    initial begin
        vec_t vecs[14];
        int ncmd, nalu, nf, n;
        logic [9:0] cmd0;
        logic [17:0] alu0;
        bit rseen, ap;
        logic [7:0] rdata;
        logic [1:0] kind;

        vecs[0]  = '{2'd0, 8'h03, 0, 1, 10'h003, 1'b1, 0, 18'h0, 1'b0, 8'h00, 1'b0, 2'd0, 0, 3'd1};
        vecs[1]  = '{2'd0, 8'h04, 0, 1, 10'h004, 1'b1, 0, 18'h0, 1'b0, 8'h00, 1'b0, 2'd0, 0, 3'd2};
        vecs[2]  = '{2'd1, 8'h00, 0, 1, 10'h207, 1'b1, 1, {2'd0, 8'h03, 8'h04}, 1'b0, 8'h00, 1'b0, 2'd0, 0, 3'd1};
        vecs[3]  = '{2'd2, 8'h00, 4, 1, 10'h300, 1'b0, 0, 18'h0, 1'b1, 8'h07, 1'b0, 2'd0, 0, 3'd0};
        vecs[4]  = '{2'd1, 8'h01, 0, 0, 10'h000, 1'b0, 0, 18'h0, 1'b0, 8'h00, 1'b1, 2'd2, 0, 3'd0};
        vecs[5]  = '{2'd0, 8'h09, 0, 1, 10'h009, 1'b1, 0, 18'h0, 1'b0, 8'h00, 1'b0, 2'd0, 0, 3'd1};
        vecs[6]  = '{2'd1, 8'h02, 0, 0, 10'h000, 1'b0, 0, 18'h0, 1'b0, 8'h00, 1'b1, 2'd2, 1, 3'd0};
        vecs[7]  = '{2'd2, 8'h00, 0, 0, 10'h000, 1'b0, 0, 18'h0, 1'b0, 8'h00, 1'b1, 2'd3, 0, 3'd0};
        vecs[8]  = '{2'd0, 8'h09, 0, 1, 10'h009, 1'b1, 0, 18'h0, 1'b0, 8'h00, 1'b0, 2'd0, 0, 3'd1};
        vecs[9]  = '{2'd3, 8'h00, 4, 1, 10'h300, 1'b0, 0, 18'h0, 1'b1, 8'h09, 1'b0, 2'd0, 0, 3'd0};
        vecs[10] = '{2'd0, 8'h80, 0, 1, 10'h080, 1'b1, 0, 18'h0, 1'b0, 8'h00, 1'b0, 2'd0, 0, 3'd1};
        vecs[11] = '{2'd0, 8'hA0, 0, 1, 10'h0A0, 1'b1, 0, 18'h0, 1'b0, 8'h00, 1'b0, 2'd0, 0, 3'd2};
        vecs[12] = '{2'd1, 8'h01, 0, 1, 10'h2E0, 1'b1, 1, {2'd1, 8'h80, 8'hA0}, 1'b0, 8'h00, 1'b0, 2'd0, 0, 3'd1};
        vecs[13] = '{2'd2, 8'h00, 1, 1, 10'h300, 1'b0, 0, 18'h0, 1'b1, 8'hE0, 1'b0, 2'd0, 0, 3'd0};

        bus.tok_valid = 1'b0; bus.tok_kind = 2'b00; bus.tok_data = 8'h00;
        bus.res_ready = 1'b0; bus.err_clr = 1'b0;
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_tok_ready", bus.tok_ready, 1);
        chk("rst_count", bus.count, 0);
        chk("rst_q_en", bus.q_en, 0);
        chk("rst_alu_start", bus.alu_start, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_err", {bus.err, bus.err_code}, 0);
        chk("rst_data_outs", {bus.q_opcode, bus.q_back, bus.alu_op, bus.alu_a, bus.alu_b, bus.res_data}, 0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) begin
            run_token(vecs[i].kind, vecs[i].data, vecs[i].hold, ncmd, cmd0, nalu, alu0, rseen, rdata);
            chk($sformatf("vec%0d_ncmd", i), ncmd, vecs[i].ncmd);
            if (vecs[i].ncmd > 0) chk($sformatf("vec%0d_opcode", i), cmd0[9:8], vecs[i].cmd[9:8]);
            if (vecs[i].chk_back) chk($sformatf("vec%0d_q_back", i), cmd0[7:0], vecs[i].cmd[7:0]);
            chk($sformatf("vec%0d_nalu", i), nalu, vecs[i].nalu);
            if (vecs[i].nalu > 0) chk($sformatf("vec%0d_alu", i), alu0, vecs[i].alu);
            chk($sformatf("vec%0d_res_seen", i), rseen, vecs[i].rseen);
            if (vecs[i].rseen) chk($sformatf("vec%0d_res_data", i), rdata, vecs[i].rdata);
            chk($sformatf("vec%0d_err", i), bus.err, vecs[i].err);
            chk($sformatf("vec%0d_err_code", i), bus.err_code, vecs[i].code);
            if (vecs[i].err) begin
                clear_err(nf, ap);
                chk($sformatf("vec%0d_flush_n", i), nf, vecs[i].flush);
            end
            chk($sformatf("vec%0d_count", i), bus.count, vecs[i].cnt);
        end

        // Overflow: five pushes fit, the sixth traps without touching the queue.
        for (int i = 0; i < 5; i++) begin
            run_token(2'd0, 8'(8'h10 + i), 0, ncmd, cmd0, nalu, alu0, rseen, rdata);
            chk("ovf_push_n", ncmd, 1);
            chk("ovf_count", bus.count, i + 1);
        end
        run_token(2'd0, 8'h16, 0, ncmd, cmd0, nalu, alu0, rseen, rdata);
        chk("ovf_no_q_en", ncmd, 0);
        chk("ovf_err", bus.err, 1);
        chk("ovf_code", bus.err_code, 2'b01);
        chk("ovf_tok_ready", bus.tok_ready, 0);
        clear_err(nf, ap);
        chk("ovf_flush_n", nf, 5);
        chk("ovf_flush_op", ap, 1);

        // Reset while waiting on the ALU, then a stale done pulse.
        run_token(2'd0, 8'h05, 0, ncmd, cmd0, nalu, alu0, rseen, rdata);
        run_token(2'd0, 8'h06, 0, ncmd, cmd0, nalu, alu0, rseen, rdata);
        alu_mute = 1'b1;
        send(2'd1, 8'h00);
        tick(); tick();
        chk("wait_busy", bus.tok_ready, 0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mid_rst_tok_ready", bus.tok_ready, 1);
        chk("mid_rst_count", bus.count, 0);
        chk("mid_rst_outs", {bus.q_en, bus.alu_start, bus.res_valid, bus.err}, 0);
        chk("mid_rst_alu_outs", {bus.alu_op, bus.alu_a, bus.alu_b}, 0);
        n = obs_q.size();
        late_req++;
        repeat (3) tick();
        chk("late_done_no_q", obs_q.size() - n, 0);
        chk("late_done_idle", bus.tok_ready, 1);
        chk("late_done_count", bus.count, 0);
        alu_mute = 1'b0;
        tick();

`ifdef QSEQ_ALU_TIMEOUT_EN
        run_token(2'd0, 8'h01, 0, ncmd, cmd0, nalu, alu0, rseen, rdata);
        run_token(2'd0, 8'h02, 0, ncmd, cmd0, nalu, alu0, rseen, rdata);
        alu_mute = 1'b1;
        send(2'd1, 8'h00);
        n = 0;
        while (!bus.err && n < BUDGET) begin tick(); n++; end
        chk("to_cycles", n, TO + 1);
        chk("to_code", bus.err_code, 2'b11);
        clear_err(nf, ap);
        chk("to_flush_n", nf, 2);
        alu_mute = 1'b0;
`endif

        mq.delete();
        for (int t = 0; t < 300; t++) begin
            n = $urandom_range(0, 99);
            kind = (n < 45) ? 2'd0 : (n < 80) ? 2'd1 : (n < 95) ? 2'd2 : 2'd3;
            model_step(kind, 8'($urandom), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/queue_calc_sequencer.md
Name: queue_calc_sequencer

Overview:
- Sequences the 5-entry byte calculator queue and the shared 8-bit ALU from a tokenised RPN-style input stream.
- Accepts operand, operator and end tokens over a valid/ready handshake. Issues one queue opcode per command cycle, launches ALU operations on the two front entries, writes results back, and returns the final value over a valid/ready result port.
- Keeps an occupancy counter that mirrors the queue depth and traps overflow and underflow.

Parameters:
DEPTH, 5, queue capacity in entries; must match the queue instance.
TIMEOUT_CYCLES, 64, ALU watchdog limit; used only with QSEQ_ALU_TIMEOUT_EN.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  reset; one clock, reset is synchronous and active-low.
tok_valid  input  1  token present.
tok_ready  output  1  token accepted when tok_valid && tok_ready.
tok_kind  input  2  00 operand, 01 operator, 10 end, 11 reserved (treated as end).
tok_data  input  8  operand value, or operator code in [1:0].
q_top  input  16  queue front pair {arr0, arr1}.
q_en  output  1  queue command strobe, one cycle.
q_opcode  output  2  00 push, 01 pop-and-push, 10 pop-pair-push-result, 11 pop-front.
q_back  output  8  queue write data.
alu_start  output  1  one-cycle ALU launch.
alu_op  output  2  operator code.
alu_a  output  8  q_top[15:8], captured at launch.
alu_b  output  8  q_top[7:0], captured at launch.
alu_done  input  1  ALU result valid.
alu_result  input  8  ALU result.
res_valid  output  1  final result valid.
res_data  output  8  final result.
res_ready  input  1  result consumer ready.
err  output  1  sticky error flag.
err_code  output  2  01 overflow, 10 underflow, 11 bad end or timeout.
err_clr  input  1  starts flush out of ERROR.
count  output  3  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst=0 at posedge): state IDLE, count=0. Every output is 0 except tok_ready, which is 1 in IDLE. Reset mid-operation aborts immediately. The system must reset the queue in the same cycle.
- All outputs are registered.
- States: IDLE, PUSH, ALU_REQ, ALU_WAIT, WRITEBACK, RESULT, ERROR, FLUSH.
- tok_ready=1 only in IDLE.
- IDLE, operand accepted:
  - count<DEPTH: go to PUSH and latch tok_data.
  - otherwise: ERROR with err_code=01.
- PUSH: q_en=1, q_opcode=00, q_back=latched data for exactly one cycle; count+1; then IDLE. A token accepted in cycle N gives q_en in cycle N+1, and tok_ready returns in cycle N+2.
- IDLE, operator accepted:
  - count>=2: go to ALU_REQ and latch the op code.
  - otherwise: ERROR with err_code=10.
- ALU_REQ: alu_start=1 for one cycle; alu_a/alu_b/alu_op are driven from q_top and held stable until WRITEBACK ends; next state ALU_WAIT.
- ALU_WAIT: hold until alu_done=1, then capture alu_result and go to WRITEBACK. alu_done arriving in the same cycle as alu_start is ignored.
- WRITEBACK: q_en=1, q_opcode=10, q_back=captured result, one cycle; count-1; then IDLE.
- IDLE, end token accepted:
  - count==1: go to RESULT.
  - otherwise (including count==0): ERROR with err_code=11.
- RESULT: res_valid=1, res_data=q_top[15:8], both held until res_ready. In the handshake cycle, q_en=1, q_opcode=11, count becomes 0, then IDLE next cycle.
- ERROR: err=1 (sticky) and err_code held; no queue commands issued; tok_ready=0. When err_clr=1, go to FLUSH.
- FLUSH: one q_en with opcode 11 per cycle while count>0, decrementing count each time. At count==0, clear err and err_code and go to IDLE. Flush with count==0 returns to IDLE in one cycle.
- Opcode 01 is never issued by this block.
- count never wraps; the overflow and underflow checks happen before any queue command.

Optional Feature:
QSEQ_ALU_TIMEOUT_EN:
- Defined: an 8-bit watchdog counts ALU_WAIT cycles. When it reaches TIMEOUT_CYCLES without alu_done, go to ERROR with err_code=11. The watchdog clears on entering ALU_REQ.
- Undefined: ALU_WAIT waits indefinitely and no watchdog logic is present.

Test Plan:
- Reset, then tokens 3, 4, op 00, end; ALU returns 7 -> q opcodes 00, 00, 10 (q_back=7), 11; res_data=7; count sequence 1, 2, 1, 0.
- Six operands in a row -> five pushes; the sixth gives err=1, err_code=01 and no q_en. Then err_clr -> five opcode-11 strobes, count=0, err=0, tok_ready=1.
- Single operand then operator -> err_code=10; no alu_start.
- Operand 9, end, with res_ready held 0 for 4 cycles -> res_valid and res_data=9 stable for 4 cycles; exactly one pop after res_ready rises.
- rst asserted during ALU_WAIT -> next cycle IDLE, count=0, outputs 0, tok_ready=1; a late alu_done is ignored.
- With QSEQ_ALU_TIMEOUT_EN and TIMEOUT_CYCLES=8, withhold alu_done -> err_code=11 after 8 ALU_WAIT cycles.
